ctrl_cmd_arbiter: RTL and testbench
===================================

CTRL_CMD_ARBITER -- requirements
Module: ctrl_cmd_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TRRD_S, 4, minimum ACT-to-ACT spacing in cycles, different bank group.
  TRRD_L, 6, minimum ACT-to-ACT spacing in cycles, same bank group.
  TFAW, 20, four-activate window in cycles.
  STARVE, 8, cycles an eligible ACT waits before promotion above CAS.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  CK_t  in  1  DDR clock; the only clock.
  reset  in  1  asynchronous, active-high reset.
  ref_req  in  1  refresh request.
  ref_gnt  out  1  refresh grant pulse.
  pre_req  in  1  precharge request.
  pre_cmd  in  cmd_t  precharge payload.
  pre_gnt  out  1  precharge grant pulse.
  cas_req  in  1  CAS request.
  cas_cmd  in  cmd_t  CAS payload; op is RD, RDA, WR or WRA.
  cas_gnt  out  1  CAS grant pulse.
  act_req  in  1  activate request.
  act_cmd  in  cmd_t  activate payload.
  act_gnt  out  1  activate grant pulse.
  cmd_valid  out  1  issued command valid.
  cmd_out  out  cmd_t  issued command.
  arb_idle  out  1  high when nothing is pending.

Function
REQ-003 One command SHALL issue per cycle at most. All outputs SHALL be registered.
REQ-004 Handshake: a request sampled high and eligible at edge N SHALL give a one-cycle *_gnt, plus cmd_valid and cmd_out equal to that request's payload, during cycle N+1.
REQ-005 The requester SHALL hold req and payload stable until its gnt. It drops req in the gnt cycle. A requester whose gnt is high SHALL be masked from selection in that cycle.
REQ-006 Priority SHALL be REF > PRE > CAS > ACT. An eligible ACT that has been pending without grant for STARVE cycles SHALL be promoted above CAS, but not above REF or PRE.
REQ-007 tRRD: if an ACT has cmd_valid at cycle T, the next ACT SHALL NOT have cmd_valid before T+TRRD_L when its bank group is the same, or before T+TRRD_S otherwise. Exactly T+TRRD_x is legal.
REQ-008 The tRRD counter SHALL saturate at 0, which means eligible. The last ACT bank group SHALL be stored.
REQ-009 A blocked ACT SHALL NOT block PRE, CAS or REF.
REQ-010 The FSM SHALL have states ARB_IDLE, ARB_ISSUE and ARB_BLOCKED. Next state is ARB_ISSUE if any request is eligible. Otherwise it is ARB_BLOCKED if any request is pending. Otherwise it is ARB_IDLE.
REQ-011 arb_idle SHALL be high exactly when the state is ARB_IDLE.
REQ-012 When cmd_valid is low, cmd_out.op SHALL be NOP.
REQ-013 The starvation counter SHALL clear on act_gnt or when act_req is low. It SHALL saturate at STARVE.

Reset
REQ-014 Reset SHALL act asynchronously and immediately.
REQ-015 Reset values SHALL be: all gnts 0, cmd_valid 0, cmd_out all zero with op NOP, arb_idle 1, state ARB_IDLE.
REQ-016 Reset SHALL also set the tRRD and starvation counters to 0 and empty the FAW history.
REQ-017 Reset asserted mid-grant SHALL drop gnt in the same cycle. No command SHALL be issued until the first edge after reset deasserts.

Configuration
REQ-018 With CMD_FAW_CHECK_EN defined, a fifth ACT SHALL NOT have cmd_valid earlier than T1+TFAW, where T1 is the oldest of the last four ACT issue cycles.
REQ-019 Without CMD_FAW_CHECK_EN, only tRRD SHALL gate ACT, and the FAW logic SHALL be absent.

Structure
REQ-020 Package ddr_pkg SHALL hold: cmd_t (op[2:0], bg[1:0], ba[1:0], addr[16:0]), the op codes NOP/ACT/RD/RDA/WR/WRA/PRE/REF, and arb_fsm_type.
REQ-021 Sub-module ctrl_faw_window SHALL be instantiated only under CMD_FAW_CHECK_EN. It takes act_issued and outputs faw_ok, using four down-counters of width $clog2(TFAW+1).

Verification
REQ-022 All four requests high in the same cycle -> ref_gnt next cycle; then pre_gnt, cas_gnt and act_gnt in consecutive cycles.
REQ-023 ACT bg0 issued at cycle 10, then ACT bg0 pending -> second cmd_valid at cycle 16. With the second ACT on bg1 instead -> cycle 14.
REQ-024 With the macro defined and ACTs to bg0..bg3 at cycles 10, 14, 18, 22, a fifth ACT pending from cycle 23 -> issued at cycle 30, not earlier. Without the macro -> issued at cycle 26.
REQ-025 cas_req held high continuously and act_req eligible -> act_gnt after 8 cycles of pending, ahead of CAS.
REQ-026 Reset asserted during an act_gnt cycle -> act_gnt and cmd_valid drop asynchronously. After release, the ACT is reissued with the tRRD counters cleared.

Source files
------------

// File: rtl/ddr_pkg.sv
// DDR command encoding shared by the command arbiter and its FAW tracker.
package ddr_pkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        RD  = 3'd2,
        RDA = 3'd3,
        WR  = 3'd4,
        WRA = 3'd5,
        PRE = 3'd6,
        REF = 3'd7
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [16:0] addr;
    } cmd_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_BLOCKED = 2'd2
    } arb_fsm_type;

    localparam cmd_t CMD_NOP = '{op: NOP, bg: 2'b0, ba: 2'b0, addr: 17'b0};

    // Payload-free command (REF has no address fields).
    function automatic cmd_t cmd_of_op(input op_e op);
        cmd_t c;
        c    = CMD_NOP;
        c.op = op;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_faw_window.sv
// Four-activate window tracker; one down-counter per ACT issued in the last TFAW cycles.
// Only compiled when CMD_FAW_CHECK_EN is defined.
`ifdef CMD_FAW_CHECK_EN
module ctrl_faw_window #(
    parameter int unsigned TFAW = 20
) (
    input  logic CK_t,
    input  logic reset,
    input  logic act_issued,
    output logic faw_ok
);

    localparam int unsigned CntW = $clog2(TFAW + 1);
    // Loaded with TFAW-1 so the slot frees exactly TFAW edges after its ACT.
    localparam logic [CntW-1:0] Load = CntW'(TFAW - 1);

    logic [3:0][CntW-1:0] cnt_q, cnt_d;
    logic                 loaded;

    always_comb begin
        cnt_d  = cnt_q;
        loaded = 1'b0;
        faw_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cnt_q[i] == '0) begin
                faw_ok = 1'b1;
                if (act_issued && !loaded) begin
                    cnt_d[i] = Load;
                    loaded   = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/ctrl_cmd_arbiter.sv
// DDR command arbiter: REF > PRE > CAS > ACT with ACT starvation promotion and tRRD gating.
// Optional four-activate-window gating is enabled with CMD_FAW_CHECK_EN.
module ctrl_cmd_arbiter
    import ddr_pkg::*;
#(
    parameter int unsigned TRRD_S = 4,
    parameter int unsigned TRRD_L = 6,
    parameter int unsigned TFAW   = 20,
    parameter int unsigned STARVE = 8
) (
    input  logic CK_t,
    input  logic reset,
    input  logic ref_req,
    output logic ref_gnt,
    input  logic pre_req,
    input  cmd_t pre_cmd,
    output logic pre_gnt,
    input  logic cas_req,
    input  cmd_t cas_cmd,
    output logic cas_gnt,
    input  logic act_req,
    input  cmd_t act_cmd,
    output logic act_gnt,
    output logic cmd_valid,
    output cmd_t cmd_out,
    output logic arb_idle
);

    localparam int unsigned RrdW = $clog2(TRRD_L + 1);
    localparam int unsigned StvW = $clog2(STARVE + 1);
    // Counter loads TRRD_L-1; a different bank group may go once it has fallen to L-S.
    localparam logic [RrdW-1:0] RrdLoad  = RrdW'(TRRD_L - 1);
    localparam logic [RrdW-1:0] RrdSlack = RrdW'(TRRD_L - TRRD_S);
    localparam logic [StvW-1:0] StvMax   = StvW'(STARVE);

    if (TRRD_S == 0 || TRRD_S > TRRD_L || TFAW == 0 || STARVE == 0) begin : g_param_check
        $error("ctrl_cmd_arbiter: inconsistent timing parameters");
    end

    arb_fsm_type     state_q, state_d;
    logic            ref_gnt_q, pre_gnt_q, cas_gnt_q, act_gnt_q;
    logic            ref_gnt_d, pre_gnt_d, cas_gnt_d, act_gnt_d;
    logic            cmd_valid_q, cmd_valid_d;
    cmd_t            cmd_q, cmd_d;
    logic [RrdW-1:0] rrd_cnt_q, rrd_cnt_d;
    logic [1:0]      last_bg_q, last_bg_d;
    logic [StvW-1:0] starve_q, starve_d;

    logic ref_ok, pre_ok, cas_ok, act_ok, act_promote;
    logic rrd_ok, faw_ok, issue, pending;

    // A requester is masked while its grant is showing.
    assign ref_ok = ref_req & ~ref_gnt_q;
    assign pre_ok = pre_req & ~pre_gnt_q;
    assign cas_ok = cas_req & ~cas_gnt_q;

    assign rrd_ok = (rrd_cnt_q == '0) ||
                    ((act_cmd.bg != last_bg_q) && (rrd_cnt_q <= RrdSlack));

    assign act_ok      = act_req & ~act_gnt_q & rrd_ok & faw_ok;
    assign act_promote = act_ok & (starve_q >= StvMax);

`ifdef CMD_FAW_CHECK_EN
    ctrl_faw_window #(
        .TFAW (TFAW)
    ) u_faw_window (
        .CK_t       (CK_t),
        .reset      (reset),
        .act_issued (act_gnt_d),
        .faw_ok     (faw_ok)
    );
`else
    assign faw_ok = 1'b1;
`endif

    always_comb begin
        ref_gnt_d = 1'b0;
        pre_gnt_d = 1'b0;
        cas_gnt_d = 1'b0;
        act_gnt_d = 1'b0;
        cmd_d     = CMD_NOP;
        if (ref_ok) begin
            ref_gnt_d = 1'b1;
            cmd_d     = cmd_of_op(REF);
        end else if (pre_ok) begin
            pre_gnt_d = 1'b1;
            cmd_d     = pre_cmd;
        end else if (act_promote) begin
            act_gnt_d = 1'b1;
            cmd_d     = act_cmd;
        end else if (cas_ok) begin
            cas_gnt_d = 1'b1;
            cmd_d     = cas_cmd;
        end else if (act_ok) begin
            act_gnt_d = 1'b1;
            cmd_d     = act_cmd;
        end
    end

    assign issue       = ref_gnt_d | pre_gnt_d | cas_gnt_d | act_gnt_d;
    assign cmd_valid_d = issue;
    assign pending     = ref_ok | pre_ok | cas_ok | (act_req & ~act_gnt_q);

    always_comb begin
        state_d = ARB_IDLE;
        if (issue) begin
            state_d = ARB_ISSUE;
        end else if (pending) begin
            state_d = ARB_BLOCKED;
        end
    end

    always_comb begin
        rrd_cnt_d = rrd_cnt_q;
        last_bg_d = last_bg_q;
        starve_d  = starve_q;
        if (act_gnt_d) begin
            rrd_cnt_d = RrdLoad;
            last_bg_d = act_cmd.bg;
        end else if (rrd_cnt_q != '0) begin
            rrd_cnt_d = rrd_cnt_q - 1'b1;
        end
        // Ageing only counts while the ACT could actually have been issued.
        if (!act_req || act_gnt_q || act_gnt_d) begin
            starve_d = '0;
        end else if (act_ok && (starve_q < StvMax)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            ref_gnt_q   <= 1'b0;
            pre_gnt_q   <= 1'b0;
            cas_gnt_q   <= 1'b0;
            act_gnt_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            rrd_cnt_q   <= '0;
            last_bg_q   <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            ref_gnt_q   <= ref_gnt_d;
            pre_gnt_q   <= pre_gnt_d;
            cas_gnt_q   <= cas_gnt_d;
            act_gnt_q   <= act_gnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            rrd_cnt_q   <= rrd_cnt_d;
            last_bg_q   <= last_bg_d;
            starve_q    <= starve_d;
        end
    end

    assign ref_gnt   = ref_gnt_q;
    assign pre_gnt   = pre_gnt_q;
    assign cas_gnt   = cas_gnt_q;
    assign act_gnt   = act_gnt_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_out   = cmd_q;
    assign arb_idle  = (state_q == ARB_IDLE);

endmodule

// File: tb/tb_ctrl_cmd_arbiter.sv
// Scoreboard bench for ctrl_cmd_arbiter; expected issues are queued with the cycle they must
// appear in (cycle n = sampled 1 time unit after the n-th rising edge since reset release).
module tb_ctrl_cmd_arbiter;
    import ddr_pkg::*;

    logic CK_t = 1'b0;
    logic reset = 1'b1;
    logic ref_req = 1'b0, pre_req = 1'b0, cas_req = 1'b0, act_req = 1'b0;
    cmd_t pre_cmd = CMD_NOP, cas_cmd = CMD_NOP, act_cmd = CMD_NOP;
    logic ref_gnt, pre_gnt, cas_gnt, act_gnt, cmd_valid, arb_idle;
    cmd_t cmd_out;

    ctrl_cmd_arbiter #(
        .TRRD_S (4),
        .TRRD_L (6),
        .TFAW   (20),
        .STARVE (8)
    ) dut (
        .CK_t      (CK_t),
        .reset     (reset),
        .ref_req   (ref_req),
        .ref_gnt   (ref_gnt),
        .pre_req   (pre_req),
        .pre_cmd   (pre_cmd),
        .pre_gnt   (pre_gnt),
        .cas_req   (cas_req),
        .cas_cmd   (cas_cmd),
        .cas_gnt   (cas_gnt),
        .act_req   (act_req),
        .act_cmd   (act_cmd),
        .act_gnt   (act_gnt),
        .cmd_valid (cmd_valid),
        .cmd_out   (cmd_out),
        .arb_idle  (arb_idle)
    );

    always #5 CK_t = ~CK_t;

    // gnt is {ref, pre, cas, act}
    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        cmd_t       cmd;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_vec;
    int   n_err;
    bit   hold_pre;
    bit   hold_cas;

    function automatic cmd_t mk(input op_e op, input logic [1:0] bg, input logic [1:0] ba,
                                input logic [16:0] addr);
        cmd_t c;
        c.op   = op;
        c.bg   = bg;
        c.ba   = ba;
        c.addr = addr;
        return c;
    endfunction

    task automatic push(input int c, input logic [3:0] g, input cmd_t cmd);
        exp_t e;
        e.cyc = c;
        e.gnt = g;
        e.cmd = cmd;
        sb.push_back(e);
    endtask

    // Advance one clock, score whatever the DUT issued, and let requesters drop on grant.
    task automatic step();
        exp_t       e;
        logic [3:0] g;
        @(posedge CK_t);
        #1;
        cyc++;
        g = {ref_gnt, pre_gnt, cas_gnt, act_gnt};
        n_vec++;
        if (cmd_valid || g != 4'b0) begin
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_issue cyc=%0d: got valid=%b gnt=%b cmd=%h, required none",
                         cyc, cmd_valid, g, cmd_out);
            end else begin
                e = sb.pop_front();
                if (cmd_valid !== 1'b1 || g !== e.gnt || cmd_out !== e.cmd || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL issue: got cyc=%0d valid=%b gnt=%b cmd=%h, required cyc=%0d gnt=%b cmd=%h",
                             cyc, cmd_valid, g, cmd_out, e.cyc, e.gnt, e.cmd);
                end
            end
        end else if (cmd_out.op !== NOP) begin
            n_err++;
            $display("FAIL nop_when_invalid cyc=%0d: got op=%0d, required %0d", cyc, cmd_out.op, NOP);
        end
        if (ref_gnt) ref_req = 1'b0;
        if (pre_gnt && !hold_pre) pre_req = 1'b0;
        if (cas_gnt && !hold_cas) cas_req = 1'b0;
        if (act_gnt) act_req = 1'b0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ref_req  = 1'b0;
        pre_req  = 1'b0;
        cas_req  = 1'b0;
        act_req  = 1'b0;
        hold_pre = 1'b0;
        hold_cas = 1'b0;
        sb.delete();
        repeat (2) @(posedge CK_t);
        @(negedge CK_t);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge CK_t);
        #1;
        n_vec++;
        if ({ref_gnt, pre_gnt, cas_gnt, act_gnt} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_gnts: got %b, required 0000", {ref_gnt, pre_gnt, cas_gnt, act_gnt});
        end
        n_vec++;
        if (cmd_valid !== 1'b0 || cmd_out !== CMD_NOP) begin
            n_err++;
            $display("FAIL reset_cmd: got valid=%b cmd=%h, required valid=0 cmd=%h",
                     cmd_valid, cmd_out, CMD_NOP);
        end
        n_vec++;
        if (arb_idle !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle: got %b, required 1", arb_idle);
        end
    endtask

    task automatic test_priority();
        do_reset();
        ref_req = 1'b1;
        pre_req = 1'b1;
        pre_cmd = mk(PRE, 2'd1, 2'd2, 17'h00000);
        cas_req = 1'b1;
        cas_cmd = mk(RD, 2'd3, 2'd1, 17'h1abcd);
        act_req = 1'b1;
        act_cmd = mk(ACT, 2'd2, 2'd0, 17'h05555);
        push(1, 4'b1000, cmd_of_op(REF));
        push(2, 4'b0100, pre_cmd);
        push(3, 4'b0010, cas_cmd);
        push(4, 4'b0001, act_cmd);
        run_to(2);
        n_vec++;
        if (arb_idle !== 1'b0) begin
            n_err++;
            $display("FAIL prio_busy_idle: got %b, required 0", arb_idle);
        end
        run_to(5);
        n_vec++;
        if (arb_idle !== 1'b1) begin
            n_err++;
            $display("FAIL prio_end_idle: got %b, required 1", arb_idle);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL prio_missing: got %0d issues outstanding, required 0", sb.size());
        end
    endtask

    // Second ACT after one at cycle 10; CAS must slip past the blocked ACT.
    task automatic test_trrd(input logic [1:0] bg2, input int exp_cyc);
        do_reset();
        run_to(9);
        act_req = 1'b1;
        act_cmd = mk(ACT, 2'd0, 2'd1, 17'h00123);
        push(10, 4'b0001, act_cmd);
        run_to(11);
        act_req = 1'b1;
        act_cmd = mk(ACT, bg2, 2'd2, 17'h00456);
        cas_req = 1'b1;
        cas_cmd = mk(WR, 2'd0, 2'd1, 17'h00040);
        push(12, 4'b0010, cas_cmd);
        push(exp_cyc, 4'b0001, act_cmd);
        run_to(13);
        n_vec++;
        if (arb_idle !== 1'b0) begin
            n_err++;
            $display("FAIL trrd_blocked_idle bg=%0d: got %b, required 0", bg2, arb_idle);
        end
        run_to(17);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL trrd_missing bg=%0d: got %0d outstanding, required 0", bg2, sb.size());
        end
    endtask

    task automatic test_faw();
        int fifth;
        do_reset();
        run_to(9);
        act_req = 1'b1;
        act_cmd = mk(ACT, 2'd0, 2'd0, 17'h00010);
        push(10, 4'b0001, act_cmd);
        for (int k = 1; k < 4; k++) begin
            run_to(10 + 4 * (k - 1));
            act_req = 1'b1;
            act_cmd = mk(ACT, 2'(k), 2'd0, 17'(16 + k));
            push(10 + 4 * k, 4'b0001, act_cmd);
        end
        run_to(22);
`ifdef CMD_FAW_CHECK_EN
        fifth = 30;
`else
        fifth = 26;
`endif
        act_req = 1'b1;
        act_cmd = mk(ACT, 2'd0, 2'd3, 17'h00020);
        push(fifth, 4'b0001, act_cmd);
        run_to(31);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL faw_missing: got %0d outstanding, required 0", sb.size());
        end
    endtask

    // PRE and CAS held high alternate (each masked in its own grant cycle); the ACT only wins
    // once aged, taking a CAS slot but never a PRE slot.
    task automatic test_starve();
        do_reset();
        hold_pre = 1'b1;
        hold_cas = 1'b1;
        pre_req  = 1'b1;
        pre_cmd  = mk(PRE, 2'd2, 2'd3, 17'h00000);
        cas_req  = 1'b1;
        cas_cmd  = mk(RDA, 2'd1, 2'd0, 17'h00777);
        act_req  = 1'b1;
        act_cmd  = mk(ACT, 2'd1, 2'd1, 17'h0a0a0);
        for (int c = 1; c <= 9; c++) begin
            if (c % 2 == 1) push(c, 4'b0100, pre_cmd);
            else            push(c, 4'b0010, cas_cmd);
        end
        push(10, 4'b0001, act_cmd);
        run_to(10);
        hold_pre = 1'b0;
        hold_cas = 1'b0;
        pre_req  = 1'b0;
        cas_req  = 1'b0;
        run_to(12);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL starve_missing: got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_grant();
        cmd_t a;
        do_reset();
        run_to(9);
        act_req = 1'b1;
        act_cmd = mk(ACT, 2'd0, 2'd0, 17'h00100);
        push(10, 4'b0001, act_cmd);
        run_to(11);
        a       = mk(ACT, 2'd0, 2'd1, 17'h00200);
        act_req = 1'b1;
        act_cmd = a;
        push(16, 4'b0001, a);
        run_to(16);
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (act_gnt !== 1'b0 || cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_drop: got act_gnt=%b valid=%b, required 0 0",
                     act_gnt, cmd_valid);
        end
        n_vec++;
        if (cmd_out !== CMD_NOP || arb_idle !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset_state: got cmd=%h idle=%b, required cmd=%h idle=1",
                     cmd_out, arb_idle, CMD_NOP);
        end
        act_req = 1'b1;
        step();
        @(negedge CK_t);
        reset = 1'b0;
        cyc   = 0;
        push(1, 4'b0001, a);
        run_to(2);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL reissue_missing: got %0d outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        hold_pre = 1'b0;
        hold_cas = 1'b0;
        test_reset();
        test_priority();
        test_trrd(2'd0, 16);
        test_trrd(2'd1, 14);
        test_faw();
        test_starve();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
